fft_pair_issuer: RTL and testbench

//  Producer side of the complex-adder operand interface: collects N complex samples from an

---
 rtl/fft_pair_issuer_pkg.sv | 19 +
 rtl/fft_pair_issuer_if.sv | 39 +++
 rtl/fft_pair_issuer_sample_bank.sv | 41 ++++
 rtl/fft_pair_issuer.sv | 163 ++++++++++++++++
 tb/tb_fft_pair_issuer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pair_issuer_pkg.sv
// rtl/fft_pair_issuer_pkg.sv - shared types and defaults for the stage-0 pair issuer
// Purpose: default frame size / component width, complex sample type, issuer FSM states.
// Ports: none (package).
package fft_pair_issuer_pkg;

  localparam int N_DEFAULT  = 16;
  localparam int DW_DEFAULT = 32;

  typedef struct packed {
    logic signed [DW_DEFAULT-1:0] re;
    logic signed [DW_DEFAULT-1:0] im;
  } cplx_t;

  typedef enum logic {
    FILL  = 1'b0,
    ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/fft_pair_issuer_if.sv
// rtl/fft_pair_issuer_if.sv - sample-in stream and pair-out bus of the pair issuer
// Purpose: bundles the upstream valid/ready sample stream and the adder operand bus.
// Ports (modport master = issuer side):
//   in_valid/in_ready/in_real/in_imag : upstream complex samples
//   valid/last/pair_idx               : pair qualifier, final pair flag, pair index k
//   real_a/imag_a/real_b/imag_b       : x[k] and x[k+N/2]
//   busy                              : issuer is presenting pairs
interface fft_pair_issuer_if
  import fft_pair_issuer_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int DW = DW_DEFAULT
);
  localparam int AW = $clog2(N);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_real;
  logic signed [DW-1:0] in_imag;
  logic                 valid;
  logic signed [DW-1:0] real_a;
  logic signed [DW-1:0] imag_a;
  logic signed [DW-1:0] real_b;
  logic signed [DW-1:0] imag_b;
  logic [AW-2:0]        pair_idx;
  logic                 last;
  logic                 busy;

  modport master (
    input  in_valid, in_real, in_imag,
    output in_ready, valid, real_a, imag_a, real_b, imag_b, pair_idx, last, busy
  );

  modport slave (
    output in_valid, in_real, in_imag,
    input  in_ready, valid, real_a, imag_a, real_b, imag_b, pair_idx, last, busy
  );

endinterface

// File: rtl/fft_pair_issuer_sample_bank.sv
// rtl/fft_pair_issuer_sample_bank.sv - N-entry complex sample regfile, 1W / 2R
// Purpose: holds one frame; read ports return entries k and k+N/2 combinationally.
// Ports: clk, rst (async, active-high), we/waddr/wdata write port ({re,im} packed),
//        raddr = k, rdata_a = bank[k], rdata_b = bank[k+N/2].
module fft_sample_bank
  import fft_pair_issuer_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [$clog2(N)-1:0]   waddr,
  input  logic [2*DW-1:0]        wdata,
  input  logic [$clog2(N)-2:0]   raddr,
  output logic [2*DW-1:0]        rdata_a,
  output logic [2*DW-1:0]        rdata_b
);

  logic [2*DW-1:0] mem_q [N];
  logic [2*DW-1:0] mem_d [N];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // The top address bit selects the lower or upper half of the frame.
  assign rdata_a = mem_q[{1'b0, raddr}];
  assign rdata_b = mem_q[{1'b1, raddr}];

endmodule

// File: rtl/fft_pair_issuer.sv
// rtl/fft_pair_issuer.sv - collects N samples, then issues stage-0 butterfly pairs
// Purpose: fills a sample bank from the upstream stream, then presents
//          (x[k], x[k+N/2]) for k = 0..N/2-1 on consecutive cycles with registered outputs.
// Ports: clk, rst (async, active-high), bus (fft_pair_issuer_if.master).
// Config: FFT_PAIR_ISSUER_PINGPONG_EN - two banks, filling continues while the other issues.
module fft_pair_issuer
  import fft_pair_issuer_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  fft_pair_issuer_if.master bus
);

  localparam int AW = $clog2(N);
  localparam int KW = AW - 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(N - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(N / 2 - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [KW-1:0]   k_q, k_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic [KW-1:0]   pair_idx_q, pair_idx_d;
  logic [DW-1:0]   real_a_q, real_a_d, imag_a_q, imag_a_d;
  logic [DW-1:0]   real_b_q, real_b_d, imag_b_q, imag_b_d;
  logic            in_ready, accept, frame_done;
  logic [2*DW-1:0] rd_a, rd_b;

`ifdef FFT_PAIR_ISSUER_PINGPONG_EN
  logic            wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]      full_q, full_d;
  logic [2*DW-1:0] rd_a0, rd_b0, rd_a1, rd_b1;

  // Stall only when the bank being written is still full (i.e. both banks are occupied).
  assign in_ready = ~rst & ~full_q[wr_bank_q];

  fft_sample_bank #(.N(N), .DW(DW)) u_bank0 (
    .clk(clk), .rst(rst), .we(accept & ~wr_bank_q), .waddr(wr_ptr_q),
    .wdata({bus.in_real, bus.in_imag}), .raddr(k_q), .rdata_a(rd_a0), .rdata_b(rd_b0)
  );
  fft_sample_bank #(.N(N), .DW(DW)) u_bank1 (
    .clk(clk), .rst(rst), .we(accept & wr_bank_q), .waddr(wr_ptr_q),
    .wdata({bus.in_real, bus.in_imag}), .raddr(k_q), .rdata_a(rd_a1), .rdata_b(rd_b1)
  );

  assign rd_a = rd_bank_q ? rd_a1 : rd_a0;
  assign rd_b = rd_bank_q ? rd_b1 : rd_b0;
`else
  assign in_ready = ~rst & (state_q == FILL);

  fft_sample_bank #(.N(N), .DW(DW)) u_bank (
    .clk(clk), .rst(rst), .we(accept), .waddr(wr_ptr_q),
    .wdata({bus.in_real, bus.in_imag}), .raddr(k_q), .rdata_a(rd_a), .rdata_b(rd_b)
  );
`endif

  assign accept     = bus.in_valid & in_ready;
  assign frame_done = accept & (wr_ptr_q == PTR_LAST);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    k_d        = k_q;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    pair_idx_d = pair_idx_q;
    real_a_d   = real_a_q;
    imag_a_d   = imag_a_q;
    real_b_d   = real_b_q;
    imag_b_d   = imag_b_q;
`ifdef FFT_PAIR_ISSUER_PINGPONG_EN
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    full_d     = full_q;
    if (frame_done) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
`endif
    if (accept) wr_ptr_d = wr_ptr_q + AW'(1);

    case (state_q)
      FILL: begin
        if (frame_done) begin
          state_d = ISSUE;
          k_d     = '0;
        end
      end
      ISSUE: begin
        valid_d    = 1'b1;
        last_d     = (k_q == K_LAST);
        pair_idx_d = k_q;
        real_a_d   = rd_a[2*DW-1:DW];
        imag_a_d   = rd_a[DW-1:0];
        real_b_d   = rd_b[2*DW-1:DW];
        imag_b_d   = rd_b[DW-1:0];
        k_d        = k_q + KW'(1);  // wraps to 0 after the last pair
        if (k_q == K_LAST) begin
`ifdef FFT_PAIR_ISSUER_PINGPONG_EN
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          // Chain straight into the other bank when it is (or is just becoming) full.
          if (!(full_q[~rd_bank_q] | frame_done)) state_d = FILL;
`else
          state_d = FILL;
`endif
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      k_q        <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      pair_idx_q <= '0;
      real_a_q   <= '0;
      imag_a_q   <= '0;
      real_b_q   <= '0;
      imag_b_q   <= '0;
`ifdef FFT_PAIR_ISSUER_PINGPONG_EN
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      k_q        <= k_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      pair_idx_q <= pair_idx_d;
      real_a_q   <= real_a_d;
      imag_a_q   <= imag_a_d;
      real_b_q   <= real_b_d;
      imag_b_q   <= imag_b_d;
`ifdef FFT_PAIR_ISSUER_PINGPONG_EN
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
`endif
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.valid    = valid_q;
  assign bus.last     = last_q;
  assign bus.pair_idx = pair_idx_q;
  assign bus.real_a   = real_a_q;
  assign bus.imag_a   = imag_a_q;
  assign bus.real_b   = real_b_q;
  assign bus.imag_b   = imag_b_q;
  assign bus.busy     = (state_q == ISSUE);

endmodule

// File: tb/tb_fft_pair_issuer.sv
// tb/tb_fft_pair_issuer.sv - self-checking bench for fft_pair_issuer
// Purpose: drives framed complex samples, predicts every output cycle from a frame/schedule model.
// Ports: none (top-level bench). Honours FFT_PAIR_ISSUER_PINGPONG_EN.
module tb_fft_pair_issuer;
  import fft_pair_issuer_pkg::*;

  localparam int N  = 16;
  localparam int DW = 32;
  localparam int H  = N / 2;
  localparam int KW = $clog2(N) - 1;
`ifdef FFT_PAIR_ISSUER_PINGPONG_EN
  localparam bit PINGPONG = 1'b1;
`else
  localparam bit PINGPONG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_pair_issuer_if #(.N(N), .DW(DW)) bus ();
  fft_pair_issuer #(.N(N), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // Model: each completed frame is scheduled to issue pair k at edge start+k,
  // start = max(completion edge + 1, end of the previous frame's issue).
  int      cyc = 0;
  int      next_free, last_done_edge, done_cnt;
  cplx_t   frame[$];
  cplx_t   exp_a[int];
  cplx_t   exp_b[int];
  int      exp_k[int];
  bit      exp_busy[int];
  int      rel_q[$];
  logic    e_ready, e_valid, e_last, e_busy;
  cplx_t   e_a, e_b;
  logic [KW-1:0] e_k;

  // Source: an offered sample is held until accepted.
  cplx_t cur;
  bit    offered;
  int    mode, offer_pct, src_idx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, expv);
    end
  endtask

  task automatic model_clear();
    frame.delete(); exp_a.delete(); exp_b.delete(); exp_k.delete(); exp_busy.delete();
    rel_q.delete();
    next_free = 0;
    e_ready = 1'b0; e_valid = 1'b0; e_last = 1'b0; e_busy = 1'b0;
    e_a = '0; e_b = '0; e_k = '0;
    offered = 1'b0;
  endtask

  task automatic model_edge();
    int st;
    if (bus.in_valid && e_ready) begin
      frame.push_back(cur);
      offered = 1'b0;
      if (frame.size() == N) begin
        st = (cyc + 1 > next_free) ? cyc + 1 : next_free;
        for (int k = 0; k < H; k++) begin
          exp_a[st + k] = frame[k];
          exp_b[st + k] = frame[k + H];
          exp_k[st + k] = k;
        end
        for (int t = st - 1; t < st + H - 1; t++) exp_busy[t] = 1'b1;
        rel_q.push_back(st + H - 1);
        next_free = st + H;
        last_done_edge = cyc;
        done_cnt++;
        frame.delete();
      end
    end
    while (rel_q.size() > 0 && rel_q[0] <= cyc) void'(rel_q.pop_front());
    e_ready = PINGPONG ? (rel_q.size() < 2) : (rel_q.size() == 0);
    if (exp_a.exists(cyc)) begin
      e_valid = 1'b1;
      e_a     = exp_a[cyc];
      e_b     = exp_b[cyc];
      e_k     = KW'(exp_k[cyc]);
      e_last  = (exp_k[cyc] == H - 1);
    end else begin
      e_valid = 1'b0;
      e_last  = 1'b0;
    end
    e_busy = exp_busy.exists(cyc);
  endtask

  task automatic gen_sample();
    case (mode)
      0:       begin cur.re = src_idx; cur.im = -src_idx; end
      1:       begin cur.re = $urandom; cur.im = $urandom; end
      default: begin cur.re = 32'h7FFF_FFFF; cur.im = 32'h8000_0000; end
    endcase
    src_idx++;
  endtask

  task automatic drive();
    if (!offered && (int'($urandom_range(99)) < offer_pct)) begin
      gen_sample();
      offered = 1'b1;
    end
    bus.in_valid = offered;
    bus.in_real  = cur.re;
    bus.in_imag  = cur.im;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst) model_edge();
    #1;
    if (!rst) drive();
  endtask

  task automatic assert_rst();
    rst = 1'b1;
    model_clear();
    bus.in_valid = 1'b0;
  endtask

  task automatic release_rst();
    rst = 1'b0;
    e_ready = 1'b1;
    drive();
  endtask

  task automatic tick_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic run_frame(output int e);
    int start_cnt;
    int budget;
    start_cnt = done_cnt;
    budget = 0;
    while (done_cnt == start_cnt && budget < 400) begin
      tick();
      budget++;
    end
    chk("frame_timeout", 64'(done_cnt != start_cnt), 64'(1));
    e = last_done_edge;
  endtask

  always @(negedge clk) begin
    chk("in_ready", 64'(bus.in_ready), 64'(e_ready));
    chk("valid",    64'(bus.valid),    64'(e_valid));
    chk("last",     64'(bus.last),     64'(e_last));
    chk("busy",     64'(bus.busy),     64'(e_busy));
    chk("pair_idx", 64'(bus.pair_idx), 64'(e_k));
    chk("real_a",   64'(bus.real_a),   64'(e_a.re));
    chk("imag_a",   64'(bus.imag_a),   64'(e_a.im));
    chk("real_b",   64'(bus.real_b),   64'(e_b.re));
    chk("imag_b",   64'(bus.imag_b),   64'(e_b.im));
  end

  initial begin
    int e;
    int lowcnt;
    int vcount;
    bus.in_valid = 1'b0;
    bus.in_real  = '0;
    bus.in_imag  = '0;
    done_cnt = 0;
    last_done_edge = 0;
    model_clear();
    mode = 0; offer_pct = 100; src_idx = 0;

    // 1: reset state
    repeat (3) tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_valid",    64'(bus.valid),    64'(0));
    chk("rst_real_b",   64'(bus.real_b),   64'(0));
    release_rst();
    tick();
    chk("rel_in_ready", 64'(bus.in_ready), 64'(1));

    // 2: ramp frame x[i] = (i, -i), continuous input
    run_frame(e);
    chk("lat_not_early", 64'(bus.valid), 64'(0));
    chk("lit_model_a3", 64'(exp_a[e + 4]), {32'sd3, -32'sd3});
    chk("lit_model_b3", 64'(exp_b[e + 4]), {32'sd11, -32'sd11});
    tick_until(e + 1);
    chk("lit_p0_valid",  64'(bus.valid),  64'(1));
    chk("lit_p0_real_a", 64'(bus.real_a), 64'(0));
    chk("lit_p0_real_b", 64'(bus.real_b), 64'(8));
    chk("lit_p0_imag_b", 64'(bus.imag_b), 64'(-32'sd8));
    tick_until(e + 8);
    chk("lit_p7_last",   64'(bus.last),     64'(1));
    chk("lit_p7_idx",    64'(bus.pair_idx), 64'(7));
    chk("lit_p7_imag_b", 64'(bus.imag_b),   64'(-32'sd15));
    tick_until(e + 9);
    chk("lit_drop_valid", 64'(bus.valid),  64'(0));
    chk("lit_hold_real_a", 64'(bus.real_a), 64'(7));

    // 3: gapped random input; in_ready low window after frame completion
    mode = 1; offer_pct = 50;
    run_frame(e);
    lowcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (!bus.in_ready) lowcnt++;
      tick();
    end
    chk("in_ready_low_cycles", 64'(lowcnt), PINGPONG ? 64'(0) : 64'(H));
    run_frame(e);
    repeat (12) tick();

    // 4: extreme values pass bit-exact
    assert_rst();
    repeat (2) tick();
    mode = 2; offer_pct = 100;
    release_rst();
    run_frame(e);
    tick_until(e + 1);
    chk("ext_real_a", 64'(bus.real_a), 64'(32'sh7FFF_FFFF));
    chk("ext_imag_a", 64'(bus.imag_a), 64'(32'sh8000_0000));
    chk("ext_imag_b", 64'(bus.imag_b), 64'(32'sh8000_0000));
    repeat (10) tick();

    // 5: reset in the middle of issuing
    assert_rst();
    repeat (2) tick();
    mode = 0; src_idx = 0;
    release_rst();
    run_frame(e);
    tick_until(e + 4);
    chk("mid_p3_idx", 64'(bus.pair_idx), 64'(3));
    assert_rst();
    #1;
    chk("mid_rst_valid", 64'(bus.valid), 64'(0));
    repeat (2) tick();
    src_idx = 40;
    release_rst();
    run_frame(e);
    tick_until(e + 1);
    chk("post_rst_real_a", 64'(bus.real_a), 64'(40));
    chk("post_rst_real_b", 64'(bus.real_b), 64'(48));
    chk("post_rst_imag_b", 64'(bus.imag_b), 64'(-32'sd48));
    repeat (10) tick();

`ifdef FFT_PAIR_ISSUER_PINGPONG_EN
    // 6: three back-to-back frames with two banks
    assert_rst();
    repeat (2) tick();
    mode = 1; offer_pct = 100;
    release_rst();
    vcount = 0; lowcnt = 0;
    repeat (60) begin
      tick();
      if (bus.valid) vcount++;
      if (!bus.in_ready) lowcnt++;
    end
    chk("pp_pairs", 64'(vcount), 64'(3 * H));
    chk("pp_in_ready_low", 64'(lowcnt), 64'(0));
`else
    vcount = 0;
`endif

    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
